// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// Produces the PC, IF/ID and ID/EX load enables and flushes. It handles
// load-use bubbles, taken-branch squashes and multi-cycle MDU waits, where a
// wait that runs too long is abandoned. A saturating counter records the
// cycles in which the PC was held.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_mdu,
    input  logic             mdu_done,
    input  logic             branch_taken,
    output logic             pc_load,
    output logic             ifid_load,
    output logic             ifid_flush,
    output logic             idex_load,
    output logic             idex_flush,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STALL_MAX = '1;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_next;
    logic              set_timeout;
    logic              lu_haz;

    // Load-use hazard: the load in EX writes a register the ID instruction reads; x0 never counts.
    always_comb begin
        lu_haz = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Next-state and output decode. MDU issue outranks a branch, and a branch outranks a load-use bubble.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        set_timeout   = 1'b0;
        pc_load       = 1'b0;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        idex_load     = 1'b0;
        idex_flush    = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (ex_is_mdu) begin
                        state_next    = MDU_WAIT;
                        wait_cnt_next = '0;
                    end else if (branch_taken) begin
                        pc_load    = 1'b1;
                        ifid_load  = 1'b1;
                        ifid_flush = 1'b1;
                        idex_load  = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu_haz) begin
                        idex_load  = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        pc_load   = 1'b1;
                        ifid_load = 1'b1;
                        idex_load = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_done || (wait_cnt == WAIT_LAST)) begin
                        pc_load     = 1'b1;
                        ifid_load   = 1'b1;
                        idex_load   = 1'b1;
                        state_next  = RUN;
                        set_timeout = !mdu_done;
                    end else begin
                        wait_cnt_next = wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Sticky timeout flag. Only a reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_timeout <= 1'b0;
        end else if (set_timeout) begin
            mdu_timeout <= 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!pc_load && (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. It runs directed scenarios,
// followed by randomized traffic checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int SAT     = 15;

    // Control vector order: {pc_load, ifid_load, ifid_flush, idex_load, idex_flush}
    localparam logic [4:0] CTL_RUN  = 5'b11010;
    localparam logic [4:0] CTL_HALT = 5'b00000;
    localparam logic [4:0] CTL_BR   = 5'b11111;
    localparam logic [4:0] CTL_LU   = 5'b00011;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_is_mdu;
    logic             mdu_done;
    logic             branch_taken;
    logic             pc_load;
    logic             ifid_load;
    logic             ifid_flush;
    logic             idex_load;
    logic             idex_flush;
    logic             mdu_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [4:0]       ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {pc_load, ifid_load, ifid_flush, idex_load, idex_flush};

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_is_mdu    (ex_is_mdu),
        .mdu_done     (mdu_done),
        .branch_taken (branch_taken),
        .pc_load      (pc_load),
        .ifid_load    (ifid_load),
        .ifid_flush   (ifid_flush),
        .idex_load    (idex_load),
        .idex_flush   (idex_flush),
        .mdu_timeout  (mdu_timeout),
        .stall_cycles (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every DUT input.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic use1, input logic use2,
                                 input logic memrd, input logic [4:0] rd,
                                 input logic mdu, input logic done, input logic br);
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = use1;
        id_use_rs2   = use2;
        ex_mem_read  = memrd;
        ex_rd        = rd;
        ex_is_mdu    = mdu;
        mdu_done     = done;
        branch_taken = br;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_HALT) begin
            errors++; $display("[TB] FAIL reset_ctl got %b want %b", ctl, CTL_HALT);
        end
        checks++;
        if (stall_cycles !== 4'd0 || mdu_timeout !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_regs got stall=%0d to=%b want 0 0", stall_cycles, mdu_timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++; $display("[TB] FAIL reset_release_ctl got %b want %b", ctl, CTL_RUN);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        @(negedge clk);
        applyStimulus(5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("[TB] FAIL lu_ctl got %b want %b", ctl, CTL_LU);
        end
        @(negedge clk);
        applyStimulus(5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++; $display("[TB] FAIL lu_after_ctl got %b want %b", ctl, CTL_RUN);
        end
        checks++;
        if (stall_cycles !== 4'd1) begin
            errors++; $display("[TB] FAIL lu_stall_cnt got %0d want 1", stall_cycles);
        end
        // A load to x0 never stalls, even when ID reads x0.
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++; $display("[TB] FAIL lu_x0_ctl got %b want %b", ctl, CTL_RUN);
        end
        // Matching register but the operand is unused: no stall.
        @(negedge clk);
        applyStimulus(5'd7, 5'd9, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++; $display("[TB] FAIL lu_unused_ctl got %b want %b", ctl, CTL_RUN);
        end
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_cycles !== 4'd1) begin
            errors++; $display("[TB] FAIL lu_x0_stall_cnt got %0d want 1", stall_cycles);
        end
    endtask

    task automatic test_branch_load_use();
        apply_reset();
        @(negedge clk);
        applyStimulus(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (ctl !== CTL_BR) begin
            errors++; $display("[TB] FAIL br_lu_ctl got %b want %b", ctl, CTL_BR);
        end
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== CTL_RUN || stall_cycles !== 4'd0) begin
            errors++; $display("[TB] FAIL br_lu_after got ctl=%b stall=%0d want %b 0", ctl, stall_cycles, CTL_RUN);
        end
    endtask

    // MDU issue with a simultaneous done that must be ignored, noise during
    // the wait, and completion on the third wait cycle.
    task automatic test_mdu_wait();
        int zeros;
        zeros = 0;
        apply_reset();
        @(negedge clk);
        applyStimulus(5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (ctl !== CTL_HALT) begin
            errors++; $display("[TB] FAIL mdu_issue_ctl got %b want %b", ctl, CTL_HALT);
        end
        if (pc_load === 1'b0) zeros++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            applyStimulus(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, (k == 3), 1'b1);
            #1;
            checks++;
            if (ctl !== ((k == 3) ? CTL_RUN : CTL_HALT)) begin
                errors++; $display("[TB] FAIL mdu_wait%0d_ctl got %b want %b", k, ctl, (k == 3) ? CTL_RUN : CTL_HALT);
            end
            if (pc_load === 1'b0) zeros++;
        end
        checks++;
        if (zeros != 3) begin
            errors++; $display("[TB] FAIL mdu_stall_len got %0d want 3", zeros);
        end
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== CTL_RUN || stall_cycles !== 4'd3 || mdu_timeout !== 1'b0) begin
            errors++; $display("[TB] FAIL mdu_after got ctl=%b stall=%0d to=%b want %b 3 0", ctl, stall_cycles, mdu_timeout, CTL_RUN);
        end
    endtask

    // Runs one MDU op that completes on the given wait cycle (0 = never).
    task automatic mdu_run(input int done_at);
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, (k == done_at), 1'b0);
            #1;
            checks++;
            if (ctl !== ((k == TIMEOUT || k == done_at) ? CTL_RUN : CTL_HALT)) begin
                errors++; $display("[TB] FAIL to_wait%0d_ctl got %b want %b", k, ctl, (k == TIMEOUT || k == done_at) ? CTL_RUN : CTL_HALT);
            end
            if (k == done_at) break;
        end
    endtask

    task automatic test_mdu_timeout();
        apply_reset();
        mdu_run(0);
        checks++;
        if (mdu_timeout !== 1'b0) begin
            errors++; $display("[TB] FAIL to_early got %b want 0", mdu_timeout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (mdu_timeout !== 1'b1 || stall_cycles !== 4'd4) begin
                errors++; $display("[TB] FAIL to_sticky got to=%b stall=%0d want 1 4", mdu_timeout, stall_cycles);
            end
        end
        apply_reset();
        mdu_run(TIMEOUT);
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (mdu_timeout !== 1'b0 || stall_cycles !== 4'd4) begin
            errors++; $display("[TB] FAIL to_done_last got to=%b stall=%0d want 0 4", mdu_timeout, stall_cycles);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        mdu_run(0);
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_HALT || stall_cycles !== 4'd0 || mdu_timeout !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst got ctl=%b stall=%0d to=%b want %b 0 0", ctl, stall_cycles, mdu_timeout, CTL_HALT);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            errors++; $display("[TB] FAIL midrst_release got %b want %b", ctl, CTL_RUN);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (stall_cycles !== 4'((i < SAT) ? i : SAT) || ctl !== CTL_LU) begin
                errors++; $display("[TB] FAIL sat_%0d got stall=%0d ctl=%b want %0d %b", i, stall_cycles, ctl, (i < SAT) ? i : SAT, CTL_LU);
            end
        end
    endtask

    // Random traffic against a model that tracks whether an MDU op is outstanding and how long it has waited.
    task automatic test_random();
        bit         busy;
        int         waited;
        bit         m_to;
        int         m_stall;
        bit         haz;
        logic [4:0] exp;
        busy = 0; waited = 0; m_to = 0; m_stall = 0;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            #1;
            haz = ex_mem_read && ex_rd != 0 &&
                  ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            if (busy)              exp = (mdu_done || waited + 1 == TIMEOUT) ? CTL_RUN : CTL_HALT;
            else if (ex_is_mdu)    exp = CTL_HALT;
            else if (branch_taken) exp = CTL_BR;
            else if (haz)          exp = CTL_LU;
            else                   exp = CTL_RUN;
            checks++;
            if (ctl !== exp) begin
                errors++; $display("[TB] FAIL rnd%0d_ctl got %b want %b", n, ctl, exp);
            end
            checks++;
            if (stall_cycles !== 4'(m_stall) || mdu_timeout !== m_to) begin
                errors++; $display("[TB] FAIL rnd%0d_regs got stall=%0d to=%b want %0d %b", n, stall_cycles, mdu_timeout, m_stall, m_to);
            end
            @(posedge clk);
            if (exp[4] == 1'b0 && m_stall < SAT) m_stall++;
            if (!busy) begin
                if (ex_is_mdu) begin busy = 1; waited = 0; end
            end else begin
                waited++;
                if (mdu_done) busy = 0;
                else if (waited == TIMEOUT) begin busy = 0; m_to = 1; end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mdu_wait();
        test_mdu_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
